multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter ALUOP_W, 3, width of alu_op (>=3).
REQ-002 SHALL have parameter MEM_HANDSHAKE, 1, 1 = memory states hold until mem_ready; 0 = memory completes in one cycle, mem_ready ignored.
REQ-003 SHALL have parameter TRAP_ILLEGAL, 1, 1 = unknown opcode enters TRAP; 0 = unknown opcode treated as NOP and returns to FETCH.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset; op in 6 opcode from instruction register; zero in 1 ALU zero flag; mem_ready in 1 memory done.
REQ-005 SHALL have outputs, each 1 bit: pc_write, pc_write_cond, branch_ne, ir_write, mem_read, mem_write, reg_write, ext_ctr, alu_src_a, illegal.
REQ-006 SHALL have 2-bit outputs: reg_dst (0 rt, 1 rd, 2 r31); wb_src (0 ALU, 1 memory, 2 PC); alu_src_b (0 reg, 1 const 4, 2 ext imm, 3 ext imm<<2); pc_src (0 ALU result, 1 ALUOut register, 2 jump target).
REQ-007 SHALL have output alu_op, ALUOP_W bits, and output state, 4 bits, current state code.
REQ-008 Clock port SHALL be clk; reset SHALL be rst, synchronous, active-high, single clock domain.

Function
REQ-009 SHALL implement a Moore FSM; all outputs SHALL be decoded from the state register only, except pc_write_cond, which is gated by zero.
REQ-010 States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, WB_R, WB_I, BRANCH, JUMP, JAL, TRAP.
REQ-011 FETCH SHALL assert mem_read, ir_write, pc_write, alu_src_b=1, pc_src=0, alu_op=add.
REQ-011a FETCH SHALL advance to DECODE when MEM_HANDSHAKE=0 or mem_ready=1.
REQ-011b While FETCH stalls, ir_write and pc_write SHALL be 0.
REQ-012 DECODE SHALL drive alu_src_b=3 (branch target precompute) and dispatch on op:
- 000000 -> EXEC_R
- addi/addiu/andi/ori/xori/lui/slti/sltiu -> EXEC_I
- lw/sw -> MEM_ADDR
- beq/bne -> BRANCH
- j -> JUMP
- jal -> JAL
- any other op -> TRAP or FETCH per TRAP_ILLEGAL
REQ-013 Opcode encodings and the alu_op mapping SHALL match the existing single-cycle decoder: add 000, sub 001, and 010, or 011, xor 100, lui 110, R-type 111; upper alu_op bits SHALL be zero.
REQ-014 ext_ctr SHALL be 1 in EXEC_I, MEM_ADDR and BRANCH.
REQ-014a ext_ctr SHALL be 0 in those states when op is andi, ori or xori (zero-extend) and when op is sltiu.
REQ-015 EXEC_R -> WB_R: reg_dst=1, wb_src=0, reg_write=1.
REQ-015a EXEC_I -> WB_I: reg_dst=0, wb_src=0, reg_write=1.
REQ-015b WB_R and WB_I SHALL each last one cycle, then go to FETCH.
REQ-016 MEM_ADDR (alu_src_a=1, alu_src_b=2, add) SHALL go to MEM_RD for lw and to MEM_WR for sw.
REQ-016a MEM_RD and MEM_WR SHALL hold while MEM_HANDSHAKE=1 and mem_ready=0.
REQ-016b mem_read and mem_write SHALL stay asserted every held cycle.
REQ-016c MEM_RD -> MEM_WB (reg_write, wb_src=1, reg_dst=0) -> FETCH; MEM_WR -> FETCH.
REQ-017 BRANCH SHALL assert pc_write_cond, alu_op=sub and pc_src=1.
REQ-017a branch_ne SHALL be 1 for bne.
REQ-017b The PC SHALL update only when zero XOR branch_ne = 1.
REQ-017c BRANCH SHALL return to FETCH next cycle.
REQ-018 JUMP SHALL assert pc_write with pc_src=2, then go to FETCH.
REQ-018a JAL SHALL additionally assert reg_write with reg_dst=2 and wb_src=2.
REQ-019 TRAP SHALL assert illegal, hold all write enables at 0, and remain in TRAP until rst.
REQ-020 No state SHALL assert mem_read and mem_write together, or reg_write together with pc_write_cond.
REQ-021 op SHALL be sampled only in DECODE and at MEM_ADDR/MEM_RD decisions; changes in op during other states SHALL have no effect.

Reset
REQ-022 On rst=1 at a clk edge, state SHALL become FETCH regardless of current state, including mid-stall in MEM_RD/MEM_WR and in TRAP.
REQ-023 While rst=1, all write enables, mem_read, mem_write and illegal SHALL be 0; remaining outputs SHALL be 0.
REQ-024 The first FETCH after rst deasserts SHALL behave per REQ-011.

Structure
REQ-025 Opcode constants, the state enumeration and alu_op codes SHALL live in a shared package, also used by the single-cycle decoder.
REQ-026 Next-state logic and output decode SHALL be separate processes in one module.
REQ-026a One sub-module, mc_alu_op_decode (op -> alu_op, ext_ctr), SHALL be instantiated.

Verification
REQ-027 addi, MEM_HANDSHAKE=0 -> states FETCH, DECODE, EXEC_I, WB_I, FETCH; reg_write=1 only in WB_I; alu_op=000.
REQ-028 lw with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1 throughout; then MEM_WB asserts reg_write=1, wb_src=1.
REQ-029 beq with zero=0, and bne with zero=0 -> BRANCH cycle: PC update 0 for beq, 1 for bne.
REQ-030 jal -> JAL cycle asserts pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wb_src=2.
REQ-031 op=111111 with TRAP_ILLEGAL=1 -> TRAP, illegal=1 held for 10 cycles; rst pulse -> FETCH, illegal=0.
REQ-031a Same op with TRAP_ILLEGAL=0 -> FETCH directly after DECODE.
REQ-032 rst asserted during MEM_WR stall -> next cycle state=FETCH, mem_write=0.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// Shared opcode, ALU-op and state encodings for the
// single-cycle and multi-cycle control paths.
package multi_cycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_EXEC_R   = 4'd2;
  localparam logic [3:0] ST_EXEC_I   = 4'd3;
  localparam logic [3:0] ST_MEM_ADDR = 4'd4;
  localparam logic [3:0] ST_MEM_RD   = 4'd5;
  localparam logic [3:0] ST_MEM_WB   = 4'd6;
  localparam logic [3:0] ST_MEM_WR   = 4'd7;
  localparam logic [3:0] ST_WB_R     = 4'd8;
  localparam logic [3:0] ST_WB_I     = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_JUMP     = 4'd11;
  localparam logic [3:0] ST_JAL      = 4'd12;
  localparam logic [3:0] ST_TRAP     = 4'd13;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       ext_ctr;
    logic       alu_src_a;
    logic       illegal;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic is_imm_op(input logic [5:0] op);
    return op == OP_ADDI || op == OP_ADDIU ||
           op == OP_ANDI || op == OP_ORI   ||
           op == OP_XORI || op == OP_LUI   ||
           op == OP_SLTI || op == OP_SLTIU;
  endfunction

endpackage

// File: rtl/mc_alu_op_decode.sv
// Opcode to ALU operation and immediate extension mode.
// Same mapping as the single-cycle decoder.
module mc_alu_op_decode
  import multi_cycle_control_pkg::*;
(
  input  logic [5:0] op,
  output logic [2:0] alu_op,
  output logic       ext_ctr
);

  always_comb begin
    alu_op  = ALU_ADD;
    ext_ctr = 1'b1;
    case (op)
      OP_RTYPE: alu_op = ALU_RTYPE;
      OP_ANDI: begin
        alu_op  = ALU_AND;
        ext_ctr = 1'b0;
      end
      OP_ORI: begin
        alu_op  = ALU_OR;
        ext_ctr = 1'b0;
      end
      OP_XORI: begin
        alu_op  = ALU_XOR;
        ext_ctr = 1'b0;
      end
      OP_LUI:  alu_op = ALU_LUI;
      // set-less-than compares by subtraction
      OP_SLTI: alu_op = ALU_SUB;
      OP_SLTIU: begin
        alu_op  = ALU_SUB;
        ext_ctr = 1'b0;
      end
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM: state register,
// next-state logic and state-decoded control outputs.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int ALUOP_W       = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               ext_ctr,
  output logic               alu_src_a,
  output logic               illegal,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_src,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [5:0] op_q;
  logic [2:0] dec_alu_op;
  logic       dec_ext;
  logic       mem_done;
  ctrl_t      c;

  assign mem_done = !MEM_HANDSHAKE || mem_ready;

  // decode works on the opcode captured in DECODE
  mc_alu_op_decode u_dec (
    .op      (op_q),
    .alu_op  (dec_alu_op),
    .ext_ctr (dec_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) op_q <= op;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (mem_done) state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (1'b1)
          op == OP_RTYPE:
            state_d = ST_EXEC_R;
          is_imm_op(op):
            state_d = ST_EXEC_I;
          op == OP_LW || op == OP_SW:
            state_d = ST_MEM_ADDR;
          op == OP_BEQ || op == OP_BNE:
            state_d = ST_BRANCH;
          op == OP_J:
            state_d = ST_JUMP;
          op == OP_JAL:
            state_d = ST_JAL;
          default:
            state_d = TRAP_ILLEGAL ? ST_TRAP : ST_FETCH;
        endcase
      end
      ST_EXEC_R: state_d = ST_WB_R;
      ST_EXEC_I: state_d = ST_WB_I;
      ST_MEM_ADDR:
        state_d = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: if (mem_done) state_d = ST_MEM_WB;
      ST_MEM_WR: if (mem_done) state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_comb begin : out_decode
    c = '0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          c.mem_read  = 1'b1;
          c.ir_write  = mem_done;
          c.pc_write  = mem_done;
          c.alu_src_b = 2'd1;
          c.alu_op    = ALU_ADD;
        end
        ST_DECODE: c.alu_src_b = 2'd3;
        ST_EXEC_R: begin
          c.alu_src_a = 1'b1;
          c.alu_op    = ALU_RTYPE;
        end
        ST_EXEC_I: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = 2'd2;
          c.alu_op    = dec_alu_op;
          c.ext_ctr   = dec_ext;
        end
        ST_MEM_ADDR: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = 2'd2;
          c.alu_op    = ALU_ADD;
          c.ext_ctr   = dec_ext;
        end
        ST_MEM_RD: c.mem_read = 1'b1;
        ST_MEM_WB: begin
          c.reg_write = 1'b1;
          c.wb_src    = 2'd1;
        end
        ST_MEM_WR: c.mem_write = 1'b1;
        ST_WB_R: begin
          c.reg_write = 1'b1;
          c.reg_dst   = 2'd1;
        end
        ST_WB_I: c.reg_write = 1'b1;
        ST_BRANCH: begin
          c.branch    = 1'b1;
          c.branch_ne = (op_q == OP_BNE);
          c.alu_src_a = 1'b1;
          c.alu_op    = ALU_SUB;
          c.pc_src    = 2'd1;
          c.ext_ctr   = dec_ext;
        end
        ST_JUMP: begin
          c.pc_write = 1'b1;
          c.pc_src   = 2'd2;
        end
        ST_JAL: begin
          c.pc_write  = 1'b1;
          c.pc_src    = 2'd2;
          c.reg_write = 1'b1;
          c.reg_dst   = 2'd2;
          c.wb_src    = 2'd2;
        end
        ST_TRAP: c.illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.branch & (zero ^ c.branch_ne);
  assign branch_ne     = c.branch_ne;
  assign ir_write      = c.ir_write;
  assign mem_read      = c.mem_read;
  assign mem_write     = c.mem_write;
  assign reg_write     = c.reg_write;
  assign ext_ctr       = c.ext_ctr;
  assign alu_src_a     = c.alu_src_a;
  assign illegal       = c.illegal;
  assign reg_dst       = c.reg_dst;
  assign wb_src        = c.wb_src;
  assign alu_src_b     = c.alu_src_b;
  assign pc_src        = c.pc_src;
  assign alu_op        = ALUOP_W'(c.alu_op);
  assign state         = rst ? ST_FETCH : state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: two instances
// (handshake+trap, and no-handshake+nop-on-illegal).
module tb_multi_cycle_control;
  import multi_cycle_control_pkg::*;

  typedef struct {
    int         inst;
    logic [3:0] st;
    logic [20:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic pcw_a, pcwc_a, bne_a, irw_a, mr_a, mw_a;
  logic rw_a, ext_a, asa_a, ill_a;
  logic [1:0] rd_a, wb_a, asb_a, pcs_a;
  logic [2:0] aop_a;
  logic [3:0] st_a;

  logic pcw_b, pcwc_b, bne_b, irw_b, mr_b, mw_b;
  logic rw_b, ext_b, asa_b, ill_b;
  logic [1:0] rd_b, wb_b, asb_b, pcs_b;
  logic [2:0] aop_b;
  logic [3:0] st_b;

  int  checks = 0;
  int  passed = 0;
  bit  fin = 1'b0;
  bit  reported = 1'b0;

  always #5 clk = ~clk;

  multi_cycle_control #(
    .ALUOP_W(3), .MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pcw_a), .pc_write_cond(pcwc_a),
    .branch_ne(bne_a), .ir_write(irw_a),
    .mem_read(mr_a), .mem_write(mw_a),
    .reg_write(rw_a), .ext_ctr(ext_a),
    .alu_src_a(asa_a), .illegal(ill_a),
    .reg_dst(rd_a), .wb_src(wb_a),
    .alu_src_b(asb_a), .pc_src(pcs_a),
    .alu_op(aop_a), .state(st_a)
  );

  multi_cycle_control #(
    .ALUOP_W(3), .MEM_HANDSHAKE(1'b0), .TRAP_ILLEGAL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .mem_ready(mem_ready),
    .pc_write(pcw_b), .pc_write_cond(pcwc_b),
    .branch_ne(bne_b), .ir_write(irw_b),
    .mem_read(mr_b), .mem_write(mw_b),
    .reg_write(rw_b), .ext_ctr(ext_b),
    .alu_src_a(asa_b), .illegal(ill_b),
    .reg_dst(rd_b), .wb_src(wb_b),
    .alu_src_b(asb_b), .pc_src(pcs_b),
    .alu_op(aop_b), .state(st_b)
  );

  wire [20:0] act_a = {pcw_a, pcwc_a, bne_a, irw_a, mr_a,
    mw_a, rw_a, ext_a, asa_a, ill_a, rd_a, wb_a, asb_a,
    pcs_a, aop_a};
  wire [20:0] act_b = {pcw_b, pcwc_b, bne_b, irw_b, mr_b,
    mw_b, rw_b, ext_b, asa_b, ill_b, rd_b, wb_b, asb_b,
    pcs_b, aop_b};

  function automatic logic [20:0] mk(
    input bit pcw, pcwc, bn, irw, mr, mw,
    input bit rw, ext, asa, ill,
    input int rd, wb, asb, pcs, aop
  );
    return {pcw, pcwc, bn, irw, mr, mw, rw, ext, asa, ill,
            2'(rd), 2'(wb), 2'(asb), 2'(pcs), 3'(aop)};
  endfunction

  localparam logic [20:0] Z   = 21'd0;
  localparam logic [20:0] FE  = mk(1,0,0,1,1,0,0,0,0,0, 0,0,1,0,0);
  localparam logic [20:0] FS  = mk(0,0,0,0,1,0,0,0,0,0, 0,0,1,0,0);
  localparam logic [20:0] DE  = mk(0,0,0,0,0,0,0,0,0,0, 0,0,3,0,0);
  localparam logic [20:0] XIA = mk(0,0,0,0,0,0,0,1,1,0, 0,0,2,0,0);
  localparam logic [20:0] XIN = mk(0,0,0,0,0,0,0,0,1,0, 0,0,2,0,2);
  localparam logic [20:0] WI  = mk(0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0);
  localparam logic [20:0] XR  = mk(0,0,0,0,0,0,0,0,1,0, 0,0,0,0,7);
  localparam logic [20:0] WR  = mk(0,0,0,0,0,0,1,0,0,0, 1,0,0,0,0);
  localparam logic [20:0] MA  = mk(0,0,0,0,0,0,0,1,1,0, 0,0,2,0,0);
  localparam logic [20:0] MR  = mk(0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0);
  localparam logic [20:0] MWB = mk(0,0,0,0,0,0,1,0,0,0, 0,1,0,0,0);
  localparam logic [20:0] MWR = mk(0,0,0,0,0,1,0,0,0,0, 0,0,0,0,0);
  localparam logic [20:0] BQ0 = mk(0,0,0,0,0,0,0,1,1,0, 0,0,0,1,1);
  localparam logic [20:0] BN0 = mk(0,1,1,0,0,0,0,1,1,0, 0,0,0,1,1);
  localparam logic [20:0] BQ1 = mk(0,1,0,0,0,0,0,1,1,0, 0,0,0,1,1);
  localparam logic [20:0] JP  = mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,2,0);
  localparam logic [20:0] JL  = mk(1,0,0,0,0,0,1,0,0,0, 2,2,0,2,0);
  localparam logic [20:0] TR  = mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0);

  task automatic s(
    input string nm, input int inst, input logic r,
    input logic [5:0] o, input logic z, input logic m,
    input logic [3:0] st, input logic [20:0] v
  );
    @(posedge clk);
    #1;
    rst = r;
    op = o;
    zero = z;
    mem_ready = m;
    sb.push_back('{inst, st, v, nm});
  endtask

  logic [3:0]  got_st;
  logic [20:0] got_v;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got_st = (e.inst == 0) ? st_a : st_b;
      got_v  = (e.inst == 0) ? act_a : act_b;
      checks++;
      if (got_st === e.st) passed++;
      else $display("FAIL %s state got %0d want %0d",
                    e.nm, got_st, e.st);
      checks++;
      if (got_v === e.v) passed++;
      else $display("FAIL %s outs got %h want %h",
                    e.nm, got_v, e.v);
      checks++;
      if (!(got_v[16] && got_v[15]) &&
          !(got_v[14] && got_v[19])) passed++;
      else $display("FAIL %s exclusive got %h want no overlap",
                    e.nm, got_v);
    end else if (fin && !reported) begin
      checks++;
      passed++;
      reported = 1'b1;
    end
  end

  initial begin
    // no handshake, nop on illegal opcode
    s("b_rst",   1, 1, OP_ADDI, 0, 0, ST_FETCH,  Z);
    s("b_fe",    1, 0, OP_ADDI, 0, 0, ST_FETCH,  FE);
    s("b_dec",   1, 0, OP_ADDI, 0, 0, ST_DECODE, DE);
    s("b_addi",  1, 0, OP_ADDI, 0, 0, ST_EXEC_I, XIA);
    s("b_wbi",   1, 0, OP_ADDI, 0, 0, ST_WB_I,   WI);
    s("b_fe2",   1, 0, OP_ADDI, 0, 0, ST_FETCH,  FE);
    s("b_dec2",  1, 0, OP_ANDI, 0, 0, ST_DECODE, DE);
    s("b_andi",  1, 0, OP_ADDI, 0, 0, ST_EXEC_I, XIN);
    s("b_wbi2",  1, 0, OP_ADDI, 0, 0, ST_WB_I,   WI);
    s("b_fe3",   1, 0, OP_ADDI, 0, 0, ST_FETCH,  FE);
    s("b_dec3",  1, 0, 6'h3f,   0, 0, ST_DECODE, DE);
    s("b_nop",   1, 0, 6'h3f,   0, 0, ST_FETCH,  FE);
    // handshake, trap on illegal opcode
    s("a_rst",   0, 1, OP_LW,   0, 0, ST_FETCH,    Z);
    s("a_fstall",0, 0, OP_LW,   0, 0, ST_FETCH,    FS);
    s("a_fe",    0, 0, OP_LW,   0, 1, ST_FETCH,    FE);
    s("a_declw", 0, 0, OP_LW,   0, 0, ST_DECODE,   DE);
    s("a_madr",  0, 0, OP_LW,   0, 0, ST_MEM_ADDR, MA);
    s("a_mrd0",  0, 0, OP_SW,   0, 0, ST_MEM_RD,   MR);
    s("a_mrd1",  0, 0, OP_SW,   0, 0, ST_MEM_RD,   MR);
    s("a_mrd2",  0, 0, OP_SW,   0, 0, ST_MEM_RD,   MR);
    s("a_mrd3",  0, 0, OP_SW,   0, 1, ST_MEM_RD,   MR);
    s("a_memwb", 0, 0, OP_SW,   0, 0, ST_MEM_WB,   MWB);
    s("a_fe2",   0, 0, OP_BEQ,  0, 1, ST_FETCH,    FE);
    s("a_decbq", 0, 0, OP_BEQ,  0, 0, ST_DECODE,   DE);
    s("a_beq_z0",0, 0, OP_BEQ,  0, 0, ST_BRANCH,   BQ0);
    s("a_fe3",   0, 0, OP_BNE,  0, 1, ST_FETCH,    FE);
    s("a_decbn", 0, 0, OP_BNE,  0, 0, ST_DECODE,   DE);
    s("a_bne_z0",0, 0, OP_BNE,  0, 0, ST_BRANCH,   BN0);
    s("a_fe4",   0, 0, OP_BEQ,  0, 1, ST_FETCH,    FE);
    s("a_decbq2",0, 0, OP_BEQ,  0, 0, ST_DECODE,   DE);
    s("a_beq_z1",0, 0, OP_BEQ,  1, 0, ST_BRANCH,   BQ1);
    s("a_fe5",   0, 0, OP_JAL,  0, 1, ST_FETCH,    FE);
    s("a_decjal",0, 0, OP_JAL,  0, 0, ST_DECODE,   DE);
    s("a_jal",   0, 0, OP_JAL,  0, 0, ST_JAL,      JL);
    s("a_fe6",   0, 0, OP_J,    0, 1, ST_FETCH,    FE);
    s("a_decj",  0, 0, OP_J,    0, 0, ST_DECODE,   DE);
    s("a_jump",  0, 0, OP_J,    0, 0, ST_JUMP,     JP);
    s("a_fe7",   0, 0, OP_RTYPE,0, 1, ST_FETCH,    FE);
    s("a_decr",  0, 0, OP_RTYPE,0, 0, ST_DECODE,   DE);
    s("a_execr", 0, 0, OP_ADDI, 0, 0, ST_EXEC_R,   XR);
    s("a_wbr",   0, 0, OP_ADDI, 0, 0, ST_WB_R,     WR);
    s("a_fe8",   0, 0, OP_SW,   0, 1, ST_FETCH,    FE);
    s("a_decsw", 0, 0, OP_SW,   0, 0, ST_DECODE,   DE);
    s("a_madr2", 0, 0, OP_SW,   0, 0, ST_MEM_ADDR, MA);
    s("a_mwr0",  0, 0, OP_SW,   0, 0, ST_MEM_WR,   MWR);
    s("a_mwr1",  0, 0, OP_SW,   0, 0, ST_MEM_WR,   MWR);
    s("a_rstwr", 0, 1, OP_SW,   0, 0, ST_FETCH,    Z);
    s("a_postwr",0, 0, OP_SW,   0, 0, ST_FETCH,    FS);
    s("a_fe9",   0, 0, 6'h3f,   0, 1, ST_FETCH,    FE);
    s("a_decill",0, 0, 6'h3f,   0, 0, ST_DECODE,   DE);
    for (int i = 0; i < 10; i++)
      s("a_trap", 0, 0, 6'(i * 7), 0, i[0], ST_TRAP, TR);
    s("a_rsttr", 0, 1, OP_ADDI, 0, 0, ST_FETCH,    Z);
    s("a_fe10",  0, 0, OP_ADDI, 0, 1, ST_FETCH,    FE);
    @(posedge clk);
    #1;
    fin = 1'b1;
    repeat (5) if (!reported) @(posedge clk);
    #1;
    if (!reported || sb.size() != 0)
      $display("FAIL drain queue left %0d want 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
